nnz_row_fetch: RTL and testbench
================================

Name: nnz_row_fetch

Overview:
Upstream feeder for the NNZ/row prediction inspector. Walks a CSR row-pointer array in memory and emits one (offset1, offset2, prediction) triple per row through a valid/ready handshake:
- offset1 = row_ptr[i+1], offset2 = row_ptr[i]
- prediction = previous row's NNZ (last-value predictor)

The inspector consumes these triples to compute the actual NNZ and check the prediction.

Parameters:
ADDR_W, 16, width of memory word address and row count
DATA_W, 32, width of row-pointer words, offsets and prediction (inspector operates at 32)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a walk; ignored while busy=1
row_base  in  ADDR_W  word address of row_ptr[0]; sampled on accepted start
num_rows  in  ADDR_W  number of rows; sampled on accepted start
mem_req  out  1  one-cycle read request pulse
mem_addr  out  ADDR_W  read address, valid with mem_req
mem_valid  in  1  read data valid, one cycle, at least 1 cycle after mem_req
mem_rdata  in  DATA_W  read data
out_valid  out  1  triple valid
out_ready  in  1  downstream accepts triple
offset1  out  DATA_W  row_ptr[i+1]
offset2  out  DATA_W  row_ptr[i]
prediction  out  DATA_W  predicted NNZ for row i
row_idx  out  ADDR_W  index i of emitted row
busy  out  1  walk in progress
done  out  1  one-cycle pulse when walk completes

Behaviour:
- Reset (async, any state): all outputs 0, state IDLE, predictor register 0.
- States: IDLE, REQ0, WAIT0, REQ, WAIT, EMIT, FIN.
- IDLE: start=1 latches row_base and num_rows, sets busy=1.
  - num_rows=0 -> FIN.
  - Otherwise -> REQ0.
- REQ0: mem_req=1, mem_addr=row_base -> WAIT0.
- WAIT0: on mem_valid, store row_ptr[0] as prev_ptr -> REQ.
- REQ: mem_req=1, mem_addr=row_base+i+1 (mod 2^ADDR_W) -> WAIT.
- WAIT: on mem_valid, drive out_valid=1 next cycle with:
  - offset1=mem_rdata, offset2=prev_ptr, prediction=pred_reg, row_idx=i
  - Then -> EMIT.
- EMIT: triple held stable while out_ready=0. On out_valid&&out_ready:
  - pred_reg <= offset1-offset2 (DATA_W, wrap modulo 2^DATA_W, no error)
  - prev_ptr <= offset1, i <= i+1, out_valid drops next cycle
  - If i+1 == num_rows -> FIN; else -> REQ.
- FIN: done=1 for one cycle, busy=0, pred_reg cleared to 0 -> IDLE.
- Exactly one outstanding read at any time. Total reads per walk = num_rows+1.
- mem_valid outside WAIT0/WAIT (including late responses after reset) is ignored.
- start during busy is ignored; no queuing.
- Row 0 prediction is always 0.
- Minimum per-row latency, mem_valid to out_valid: 1 cycle.

Optional Feature:
Macro EMPTY_ROW_SKIP_EN.
- Defined: a row whose offset1==offset2 is not emitted. From WAIT the block updates prev_ptr and i internally, leaves pred_reg unchanged, and goes to REQ or FIN directly; out_valid stays 0. row_idx of emitted rows keeps the original index.
- Undefined: every row is emitted, including empty rows.

Test Plan:
- Reset: assert rst mid-walk (in WAIT) -> all outputs 0 immediately; subsequent mem_valid ignored; busy=0; next start works normally.
- Basic walk: row_base=0x10, num_rows=3, mem row_ptr={0,3,3,7}, latency 1, out_ready=1 -> reads at 0x10..0x13; triples (3,0,pred 0,idx 0), (3,3,pred 3,idx 1), (7,3,pred 0,idx 2); done pulse once.
- Backpressure: same as basic walk with out_ready=0 for 5 cycles on row 1 -> offset1=3, offset2=3, prediction=3 held stable; no mem_req while stalled.
- num_rows=0: start -> no mem_req; done=1 exactly 2 cycles after start; out_valid never 1.
- Wrap/start-ignore: row_ptr={0xFFFFFFF0,0x00000004} -> offset1-offset2 = 0x14 used as next prediction. Second start during busy has no effect.
- EMPTY_ROW_SKIP_EN defined, basic walk data -> only (3,0,pred 0,idx 0) and (7,3,pred 3,idx 2) emitted.

Source files
------------

// File: rtl/nnz_row_fetch.sv
// CSR row-pointer walker: emits (row_ptr[i+1], row_ptr[i], last-value NNZ prediction) per row.
// Optional build macro EMPTY_ROW_SKIP_EN suppresses rows whose NNZ is zero.
module nnz_row_fetch #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] row_base,
  input  logic [ADDR_W-1:0] num_rows,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] offset1,
  output logic [DATA_W-1:0] offset2,
  output logic [DATA_W-1:0] prediction,
  output logic [ADDR_W-1:0] row_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ0  = 3'd1;
  localparam logic [2:0] S_WAIT0 = 3'd2;
  localparam logic [2:0] S_REQ   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_EMIT  = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  logic [2:0]        state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] rows_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_next;
  logic [DATA_W-1:0] prev_ptr;
  logic [DATA_W-1:0] pred_reg;
  logic              last_row;

  assign idx_next = idx_q + ADDR_W'(1);
  assign last_row = (idx_next == rows_q);

  // Request strobe and address decode straight from state, so a single
  // request cycle per REQ state guarantees one outstanding read.
  assign mem_req = (state == S_REQ0) || (state == S_REQ);

  always_comb begin
    mem_addr = '0;
    if (state == S_REQ0)     mem_addr = base_q;
    else if (state == S_REQ) mem_addr = base_q + idx_next;
  end

  // NOTE: every state element, including the data-path registers, is cleared
  // by the async reset so all outputs read 0 the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      base_q     <= '0;
      rows_q     <= '0;
      idx_q      <= '0;
      prev_ptr   <= '0;
      pred_reg   <= '0;
      out_valid  <= 1'b0;
      offset1    <= '0;
      offset2    <= '0;
      prediction <= '0;
      row_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; done defaults low so it
      // can only ever be a single-cycle pulse.
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q <= row_base;
            rows_q <= num_rows;
            idx_q  <= '0;
            busy   <= 1'b1;
            state  <= (num_rows == '0) ? S_FIN : S_REQ0;
          end
        end
        S_REQ0: state <= S_WAIT0;
        S_WAIT0: begin
          if (mem_valid) begin
            prev_ptr <= mem_rdata;
            state    <= S_REQ;
          end
        end
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          if (mem_valid) begin
`ifdef EMPTY_ROW_SKIP_EN
            if (mem_rdata == prev_ptr) begin
              // Empty row: advance silently, prediction carries over.
              prev_ptr <= mem_rdata;
              idx_q    <= idx_next;
              state    <= last_row ? S_FIN : S_REQ;
            end else
`endif
            begin
              out_valid  <= 1'b1;
              offset1    <= mem_rdata;
              offset2    <= prev_ptr;
              prediction <= pred_reg;
              row_idx    <= idx_q;
              state      <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pred_reg  <= offset1 - offset2;
            prev_ptr  <= offset1;
            idx_q     <= idx_next;
            state     <= last_row ? S_FIN : S_REQ;
          end
        end
        S_FIN: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          pred_reg <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nnz_row_fetch.sv
// Scoreboard bench for nnz_row_fetch: a memory responder, a ready driver and an
// output monitor run beside the stimulus; expectations come from a CSR row model.
module tb_nnz_row_fetch;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] row_base;
  logic [15:0] num_rows;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] offset1;
  logic [31:0] offset2;
  logic [31:0] prediction;
  logic [15:0] row_idx;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [31:0] o1;
    logic [31:0] o2;
    logic [31:0] pred;
    logic [15:0] idx;
  } trip_t;

  trip_t       exp_q[$];
  logic [15:0] addr_q[$];
  logic [31:0] mem [0:65535];

  int n_checks   = 0;
  int n_fail     = 0;
  int reads      = 0;
  int done_cnt   = 0;
  bit outstanding = 0;
  int lat_min    = 1;
  int lat_max    = 1;
  bit rand_ready = 0;
  int stall_row  = -1;
  int stall_left = 0;

  nnz_row_fetch #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .row_base(row_base), .num_rows(num_rows),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .offset1(offset1), .offset2(offset2),
    .prediction(prediction), .row_idx(row_idx), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ctrl"}, {mem_req, out_valid, busy, done}, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_off1"}, offset1, 0);
    check({tag, "_off2"}, offset2, 0);
    check({tag, "_pred"}, prediction, 0);
    check({tag, "_idx"},  row_idx, 0);
  endtask

  // Memory responder: one read at a time, latency lat_min..lat_max cycles.
  initial begin : responder
    logic [15:0] a;
    int          lat;
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && mem_req) begin
        a = mem_addr;
        if (addr_q.size() == 0) check("unexpected_read", 1, 0);
        else                    check("read_addr", a, addr_q.pop_front());
        reads++;
        outstanding = 1'b1;
        lat = $urandom_range(lat_max, lat_min);
        for (int k = 1; k < lat; k++) begin
          @(posedge clk);
          @(negedge clk);
          check("single_outstanding", mem_req, 0);
        end
        @(posedge clk);
        #1 mem_valid = 1'b1;
        mem_rdata = mem[a];
        @(posedge clk);
        #1 mem_valid = 1'b0;
        mem_rdata = $urandom;
        outstanding = 1'b0;
      end
    end
  end

  initial begin : ready_driver
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid && int'(row_idx) == stall_row && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        out_ready = ($urandom_range(3, 0) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  initial begin : monitor
    trip_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) begin
          check("no_req_while_valid", mem_req, 0);
          if (exp_q.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            e = exp_q[0];
            check("offset1",    offset1,    e.o1);
            check("offset2",    offset2,    e.o2);
            check("prediction", prediction, e.pred);
            check("row_idx",    row_idx,    e.idx);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  // Reference: rows straight from the CSR array, last-value NNZ predictor.
  task automatic load_model(input logic [15:0] base, input int n);
    logic [31:0] o1, o2, pred;
    pred = '0;
    if (n > 0)
      for (int k = 0; k <= n; k++) addr_q.push_back(16'(int'(base) + k));
    for (int r = 0; r < n; r++) begin
      o2 = mem[16'(int'(base) + r)];
      o1 = mem[16'(int'(base) + r + 1)];
`ifdef EMPTY_ROW_SKIP_EN
      if (o1 == o2) continue;
`endif
      exp_q.push_back('{o1: o1, o2: o2, pred: pred, idx: 16'(r)});
      pred = o1 - o2;
    end
  endtask

  task automatic run_walk(input string tag, input logic [15:0] base, input int n,
                          input bit extra_start);
    int cyc, r0, d0;
    load_model(base, n);
    r0 = reads;
    d0 = done_cnt;
    @(posedge clk);
    #1 row_base = base;
    num_rows = 16'(n);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    row_base = 16'($urandom);
    num_rows = 16'($urandom_range(9, 1));
    cyc = 1;
    check({tag, "_busy"}, busy, 1);
    while (!done && cyc < 3000) begin
      start = extra_start && (cyc == 3);
      @(posedge clk);
      #1 cyc++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, done, 1);
    if (n == 0) check({tag, "_done_latency"}, cyc, 2);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_rows_left"}, exp_q.size(), 0);
    check({tag, "_reads_left"}, addr_q.size(), 0);
    check({tag, "_read_count"}, reads - r0, (n == 0) ? 0 : n + 1);
    exp_q.delete();
    addr_q.delete();
  endtask

  initial begin : stimulus
    logic [15:0] base;
    logic [31:0] p;
    int          n, r0;
    for (int k = 0; k < 65536; k++) mem[k] = $urandom;
    rst = 1'b1;
    start = 1'b0;
    row_base = '0;
    num_rows = '0;
    repeat (3) @(posedge clk);
    #1 reset_checks("por");
    rst = 1'b0;

    mem[16'h10] = 32'd0;
    mem[16'h11] = 32'd3;
    mem[16'h12] = 32'd3;
    mem[16'h13] = 32'd7;
    run_walk("basic", 16'h10, 3, 1'b0);

    stall_row = 1;
    stall_left = 5;
    run_walk("stall", 16'h10, 3, 1'b0);
    stall_row = -1;
    stall_left = 0;

    run_walk("zero", 16'h20, 0, 1'b0);

    lat_min = 1;
    lat_max = 3;
    mem[16'hFFFF] = 32'hFFFF_FFF0;
    mem[16'h0000] = 32'h0000_0004;
    mem[16'h0001] = 32'h0000_0010;
    run_walk("wrap", 16'hFFFF, 2, 1'b1);

    // Reset while the second read is outstanding; its late reply must be ignored.
    lat_min = 4;
    lat_max = 4;
    for (int k = 0; k < 4; k++) mem[16'h40 + k] = 32'(k * 5);
    load_model(16'h40, 3);
    r0 = reads;
    @(posedge clk);
    #1 row_base = 16'h40;
    num_rows = 16'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 100 && reads < r0 + 2; k++) @(negedge clk);
    check("rst_reach_wait", reads, r0 + 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 reset_checks("rst_mid");
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    for (int k = 0; k < 20 && outstanding; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1 check("rst_after_late", {busy, out_valid, mem_req, done}, 0);
    lat_min = 1;
    lat_max = 1;
    run_walk("post_rst", 16'h10, 3, 1'b0);

    rand_ready = 1'b1;
    lat_min = 1;
    lat_max = 3;
    for (int w = 0; w < 8; w++) begin
      base = 16'($urandom);
      n = $urandom_range(10, 0);
      p = $urandom;
      for (int k = 0; k <= n; k++) begin
        mem[16'(int'(base) + k)] = p;
        p = p + (($urandom_range(2, 0) == 0) ? 32'd0 : 32'($urandom_range(50, 1)));
      end
      run_walk("rand", base, n, (n > 0) && ($urandom_range(1, 0) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
